// File: rtl/i2s_rx.sv
// I2S stereo receiver: oversamples BCLK/LRCK/SDATA in the system clock domain and
// emits left/right sample pairs with a one-clock valid strobe.
module i2s_rx #(
    parameter int DATA_W      = 24,
    parameter int SLOT_MAX    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdata,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(SLOT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   bclk_prev_q;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   sdata_s;
    logic                   rise;

    logic              chan_q, chan_d;
    logic              chan_last_q, chan_last_d;
    logic [1:0]        hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] out_l_q, out_l_d;
    logic [DATA_W-1:0] out_r_q, out_r_d;
    logic              started_q, started_d;
    logic              left_ok_q, left_ok_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              slot_start;
    logic              err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
            lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign rise    = bclk_s & ~bclk_prev_q;

    // hist_q counts rises since enable (up to 2) so that a slot start is only
    // recognised once both the current and the previous channel are real samples;
    // otherwise the stale channel register could fake a start mid-slot.
    always_comb begin
        chan_d      = chan_q;
        chan_last_d = chan_last_q;
        hist_d      = hist_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_l_d    = hold_l_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        started_d   = started_q;
        left_ok_d   = left_ok_q;
        out_valid_d = 1'b0;
        slot_start  = 1'b0;
        err_set     = 1'b0;

        if (!enable) begin
            cnt_d     = '0;
            shift_d   = '0;
            started_d = 1'b0;
            left_ok_d = 1'b0;
            hist_d    = 2'd0;
        end else if (rise) begin
            chan_d      = lrck_s;
            chan_last_d = chan_q;
            if (hist_q != 2'd2) begin
                hist_d = hist_q + 2'd1;
            end
            slot_start = (hist_q == 2'd2) && (chan_q != chan_last_q);

            if (slot_start) begin
                cnt_d   = '0;
                shift_d = '0;
                // The slot being closed belongs to the previous channel.
                if (started_q) begin
                    err_set = (cnt_q < CNT_LAST) || (cnt_q == CNT_SAT);
                    if (!chan_last_q) begin
                        hold_l_d  = shift_q;
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        out_l_d     = hold_l_q;
                        out_r_d     = shift_q;
                        out_valid_d = 1'b1;
                        left_ok_d   = 1'b0;
                    end
                end
                started_d = 1'b1;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end

            for (int i = 0; i < DATA_W; i++) begin
                if (cnt_d == CNT_W'(DATA_W - 1 - i)) begin
                    shift_d[i] = sdata_s;
                end
            end
        end

        frame_err_d = err_set | (frame_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q      <= 1'b0;
            chan_last_q <= 1'b0;
            hist_q      <= 2'd0;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_l_q    <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            started_q   <= 1'b0;
            left_ok_q   <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            chan_q      <= chan_d;
            chan_last_q <= chan_last_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_l_q    <= hold_l_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            started_q   <= started_d;
            left_ok_q   <= left_ok_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: streams of I2S slots are generated bit by bit,
// expected stereo pairs are queued at build time and popped by a monitor.
module tb_i2s_rx;

    localparam int DATA_W      = 24;
    localparam int SLOT_MAX    = 32;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              bclk = 1'b0;
    logic              lrck = 1'b0;
    logic              sdata = 1'b0;
    logic              errClr = 1'b0;
    logic              outValid;
    logic [DATA_W-1:0] outL;
    logic [DATA_W-1:0] outR;
    logic              frameErr;

    int          numChecks = 0;
    int          numErrors = 0;
    logic [47:0] expQ[$];
    bit          lrq[$];
    bit          bq[$];
    bit          errExp = 1'b0;
    bit          prevValid = 1'b0;
    logic [47:0] popped;

    always #5 clk = ~clk;

    i2s_rx #(
        .DATA_W(DATA_W),
        .SLOT_MAX(SLOT_MAX),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .i2s_bclk(bclk),
        .i2s_lrck(lrck),
        .i2s_sdata(sdata),
        .err_clr(errClr),
        .out_valid(outValid),
        .out_l(outL),
        .out_r(outR),
        .frame_err(frameErr)
    );

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        numChecks++;
        if (act !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A slot shorter than the sample width keeps only its leading bits.
    function automatic logic [23:0] justify(input logic [23:0] s, input int len);
        logic [23:0] m;
        m = '1;
        if (len < DATA_W) m = m << (DATA_W - len);
        return s & m;
    endfunction

    task automatic addSlot(input bit ch, input int len, input logic [23:0] s);
        for (int j = 0; j < len; j++) begin
            lrq.push_back(ch);
            bq.push_back(j < DATA_W ? s[DATA_W-1-j] : 1'($urandom_range(1)));
        end
    endtask

    task automatic addFrame(input int lenL, input int lenR, input logic [23:0] l,
                            input logic [23:0] r, input bit expectOut);
        addSlot(1'b0, lenL, l);
        addSlot(1'b1, lenR, r);
        if (expectOut) expQ.push_back({justify(l, lenL), justify(r, lenR)});
        if (lenL < DATA_W || lenL > SLOT_MAX || lenR < DATA_W || lenR > SLOT_MAX) errExp = 1'b1;
    endtask

    task automatic addPreamble();
        addSlot(1'b0, 32, 24'($urandom));
        addSlot(1'b1, 32, 24'($urandom));
    endtask

    task automatic clearErr();
        @(posedge clk); #2 errClr = 1'b1;
        @(posedge clk); #2 errClr = 1'b0;
        errExp = 1'b0;
        @(negedge clk);
        checkOutput("err_clr", 48'(frameErr), 48'(0));
    endtask

    // Plays the built stream with the one-bit I2S delay: data trails LRCK by one BCLK.
    task automatic applyStimulus(input int enAt, input int rstAt, input int clrAt);
        addSlot(1'b0, 4, 24'h0);
        @(posedge clk); #2 enable = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        for (int n = 0; n < lrq.size(); n++) begin
            bclk  = 1'b0;
            lrck  = lrq[n];
            sdata = (n == 0) ? 1'b0 : bq[n-1];
            if (n == enAt) enable = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk); #2;
                if (n == rstAt && k == 1) rst_n = 1'b0;
                if (n == rstAt && k == HALF) begin
                    checkOutput("rst_valid", 48'(outValid), 48'(0));
                    checkOutput("rst_out_l", 48'(outL), 48'(0));
                    checkOutput("rst_out_r", 48'(outR), 48'(0));
                    checkOutput("rst_frame_err", 48'(frameErr), 48'(0));
                    rst_n  = 1'b1;
                    errExp = 1'b0;
                end
            end
            bclk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk); #2;
                errClr = (n == clrAt && k == SYNC_STAGES);
            end
        end
        errClr = 1'b0;
        lrq.delete();
        bq.delete();
        repeat (100) @(posedge clk);
        @(negedge clk);
        checkOutput("drain", 48'(expQ.size()), 48'(0));
        checkOutput("frame_err", 48'(frameErr), 48'(errExp));
    endtask

    // Monitor: every strobe must match the oldest queued pair and last one clock.
    always @(negedge clk) begin
        if (outValid) begin
            checkOutput("pulse_width", 48'(prevValid), 48'(0));
            if (expQ.size() == 0) begin
                numChecks++;
                numErrors++;
                $display("[TB] FAIL unexpected_pulse: got %h expected no pulse", {outL, outR});
            end else begin
                popped = expQ.pop_front();
                checkOutput("pair", {outL, outR}, popped);
            end
        end
        prevValid = outValid;
    end

    initial begin
        // Reset held with toggling inputs
        repeat (20) begin
            @(posedge clk); #2;
            bclk   = 1'($urandom_range(1));
            lrck   = 1'($urandom_range(1));
            sdata  = 1'($urandom_range(1));
            enable = 1'($urandom_range(1));
        end
        checkOutput("reset_valid", 48'(outValid), 48'(0));
        checkOutput("reset_out_l", 48'(outL), 48'(0));
        checkOutput("reset_out_r", 48'(outR), 48'(0));
        checkOutput("reset_frame_err", 48'(frameErr), 48'(0));
        bclk = 1'b0; lrck = 1'b0; sdata = 1'b0; enable = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        $display("[TB] nominal 32-bit slots");
        addPreamble();
        repeat (4) addFrame(32, 32, 24'h07A120, 24'hF85EE0, 1'b1);
        applyStimulus(0, -1, -1);

        $display("[TB] enable raised mid right slot");
        addPreamble();
        repeat (2) addFrame(32, 32, 24'($urandom), 24'($urandom), 1'b1);
        applyStimulus(48, -1, -1);

        $display("[TB] exact 24-bit slots");
        addPreamble();
        repeat (2) addFrame(24, 24, 24'h800000, 24'h7FFFFF, 1'b1);
        applyStimulus(0, -1, -1);

        $display("[TB] short 16-bit slots");
        addPreamble();
        repeat (2) addFrame(16, 16, 24'h123400, 24'hABCD00, 1'b1);
        applyStimulus(0, -1, -1);
        clearErr();
        addPreamble();
        addFrame(32, 32, 24'($urandom), 24'($urandom), 1'b1);
        applyStimulus(0, -1, -1);
        addPreamble();
        addFrame(16, 16, 24'h123400, 24'hABCD00, 1'b1);
        applyStimulus(0, -1, -1);
        clearErr();

        $display("[TB] err_clr coincident with a new error");
        addPreamble();
        addFrame(16, 32, 24'h123400, 24'($urandom), 1'b1);
        applyStimulus(0, -1, 64 + 16 + 1);

        $display("[TB] reset during a left slot");
        addPreamble();
        addFrame(32, 32, 24'($urandom), 24'($urandom), 1'b0);
        repeat (2) addFrame(32, 32, 24'($urandom), 24'($urandom), 1'b1);
        applyStimulus(0, 64 + 10, -1);

        $display("[TB] randomized slot lengths");
        for (int t = 0; t < 3; t++) begin
            clearErr();
            addPreamble();
            repeat (3) addFrame($urandom_range(40, 16), $urandom_range(40, 16),
                                24'($urandom), 24'($urandom), 1'b1);
            applyStimulus(0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
